// File: rtl/vp_recovery_unit_pkg.sv
// ---------------------------------------------------------------------------
// vp_recovery_unit_pkg
// Shared definitions for the value-prediction recovery unit: address/data
// widths, the recovery FSM state encoding, the undo-log entry layout and a
// helper that computes the fall-through PC used for the fetch redirect.
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vp_recovery_unit_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPEC   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_REWIND = 3'd3,
    ST_FINISH = 3'd4
  } vp_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } log_entry_t;

  // Execution resumes at the instruction following the mispredicted load.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/vp_recovery_unit_if.sv
// ---------------------------------------------------------------------------
// vp_recovery_unit_if
// Bundles the pipeline-facing signals of the recovery unit.
//   Requests : spec_start/spec_pc, wb_valid/wb_rd/wb_old_data,
//              en_recover, vp_done
//   Responses: restore_valid/rd/data, flush, redirect_valid/pc,
//              recovery_done, spec_stall, busy, overflow_err
//              (+ recover_cnt/confirm_cnt when VP_RECOVERY_STATS_EN)
// modport slave  : the recovery unit
// modport master : the pipeline / testbench driving it
// ---------------------------------------------------------------------------
interface vp_recovery_unit_if;
  import vp_recovery_unit_pkg::*;

  logic              spec_start;
  logic [ADDR_W-1:0] spec_pc;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_old_data;
  logic              en_recover;
  logic              vp_done;

  logic              restore_valid;
  logic [REG_W-1:0]  restore_rd;
  logic [DATA_W-1:0] restore_data;
  logic              flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              recovery_done;
  logic              spec_stall;
  logic              busy;
  logic              overflow_err;
`ifdef VP_RECOVERY_STATS_EN
  logic [31:0]       recover_cnt;
  logic [31:0]       confirm_cnt;
`endif

  modport slave (
    input  spec_start, spec_pc, wb_valid, wb_rd, wb_old_data, en_recover, vp_done,
    output restore_valid, restore_rd, restore_data, flush, redirect_valid,
           redirect_pc, recovery_done, spec_stall, busy, overflow_err
`ifdef VP_RECOVERY_STATS_EN
    , output recover_cnt, confirm_cnt
`endif
  );

  modport master (
    output spec_start, spec_pc, wb_valid, wb_rd, wb_old_data, en_recover, vp_done,
    input  restore_valid, restore_rd, restore_data, flush, redirect_valid,
           redirect_pc, recovery_done, spec_stall, busy, overflow_err
`ifdef VP_RECOVERY_STATS_EN
    , input recover_cnt, confirm_cnt
`endif
  );

endinterface

// File: rtl/vp_recovery_unit_undo_log.sv
// ---------------------------------------------------------------------------
// vp_undo_log
// LIFO of {rd, old data} entries recorded during speculation.
//   clk, rst   : clock, async active-high reset (empties the log)
//   clr        : synchronous discard of all entries (wins over push/pop)
//   push/push_entry : append an entry; ignored when full
//   pop        : remove the newest entry; ignored when empty
//   top_entry  : newest entry (zero when empty)
//   full/empty/count : occupancy
// ---------------------------------------------------------------------------
module vp_undo_log
  import vp_recovery_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  log_entry_t       push_entry,
  input  logic             pop,
  output log_entry_t       top_entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);

  log_entry_t       mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [IDX_W-1:0] top_idx;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == CNT_W'(0));
  assign count   = cnt_q;
  assign wr_en   = push && !full && !clr;
  assign top_idx = IDX_W'(cnt_q - CNT_W'(1));

  // Occupancy update: clear beats push, push beats pop.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_W'(0);
    end else if (wr_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q[IDX_W-1:0]] <= push_entry;
    end
  end

  // Newest entry, forced to zero when nothing is stored.
  always_comb begin
    if (empty) begin
      top_entry = '0;
    end else begin
      top_entry = mem_q[top_idx];
    end
  end

endmodule

// File: rtl/vp_recovery_unit.sv
// ---------------------------------------------------------------------------
// vp_recovery_unit
// Recovers architectural register state after a load value misprediction.
// While speculating it logs the pre-write value of every register write;
// on a mismatch it flushes, replays the log newest-first through the
// regfile undo port, then redirects fetch to the load PC + 4.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : vp_recovery_unit_if.slave (requests in, restore/redirect out)
// Parameter LOG_DEPTH : undo-log entries (power of two, 2..32).
// Optional macro VP_RECOVERY_STATS_EN adds saturating recover_cnt /
// confirm_cnt event counters on the interface.
// ---------------------------------------------------------------------------
module vp_recovery_unit
  import vp_recovery_unit_pkg::*;
#(
  parameter int LOG_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  vp_recovery_unit_if.slave    bus
);

  localparam int CNT_W = $clog2(LOG_DEPTH) + 1;

  vp_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;

  logic              log_clr, log_push, log_pop;
  logic              log_full, log_empty;
  logic [CNT_W-1:0]  log_count;
  log_entry_t        log_top, log_wr;

  assign log_wr = '{rd: bus.wb_rd, data: bus.wb_old_data};

  vp_undo_log #(.DEPTH(LOG_DEPTH)) u_log (
    .clk        (clk),
    .rst        (rst),
    .clr        (log_clr),
    .push       (log_push),
    .push_entry (log_wr),
    .pop        (log_pop),
    .top_entry  (log_top),
    .full       (log_full),
    .empty      (log_empty),
    .count      (log_count)
  );

  // State, latched load PC and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state and log control.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    log_clr  = 1'b0;
    log_push = 1'b0;
    log_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.spec_start) begin
          state_d = ST_SPEC;
          pc_d    = bus.spec_pc;
          log_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SPEC: begin
        // r0 is hardwired, so its writes never need undoing.
        if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
          if (log_full) begin
            ovf_d = 1'b1;
          end else begin
            log_push = 1'b1;
          end
        end else begin
          log_push = 1'b0;
        end
        // A mismatch outranks a simultaneous confirmation.
        if (bus.en_recover) begin
          state_d = ST_FLUSH;
        end else if (bus.vp_done) begin
          state_d = ST_IDLE;
          log_clr = 1'b1;
        end else begin
          state_d = ST_SPEC;
        end
      end
      ST_FLUSH: begin
        if (log_empty) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_REWIND;
        end
      end
      ST_REWIND: begin
        log_pop = 1'b1;
        if (log_count <= CNT_W'(1)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_REWIND;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state flops so reset clears them immediately.
  always_comb begin
    bus.busy           = (state_q != ST_IDLE);
    bus.flush          = (state_q == ST_FLUSH);
    bus.recovery_done  = (state_q == ST_FINISH);
    bus.redirect_valid = (state_q == ST_FINISH);
    bus.spec_stall     = (state_q == ST_SPEC) && log_full;
    bus.overflow_err   = ovf_q;
    if (state_q == ST_REWIND) begin
      bus.restore_valid = 1'b1;
      bus.restore_rd    = log_top.rd;
      bus.restore_data  = log_top.data;
    end else begin
      bus.restore_valid = 1'b0;
      bus.restore_rd    = 5'd0;
      bus.restore_data  = '0;
    end
    if (state_q == ST_FINISH) begin
      bus.redirect_pc = next_pc(pc_q);
    end else begin
      bus.redirect_pc = '0;
    end
  end

`ifdef VP_RECOVERY_STATS_EN
  logic [31:0] rec_cnt_q, rec_cnt_d;
  logic [31:0] conf_cnt_q, conf_cnt_d;

  // Saturating event counters: FINISH entries and confirmations in SPEC.
  always_comb begin
    rec_cnt_d  = rec_cnt_q;
    conf_cnt_d = conf_cnt_q;
    if ((state_d == ST_FINISH) && (state_q != ST_FINISH) && (rec_cnt_q != 32'hFFFF_FFFF)) begin
      rec_cnt_d = rec_cnt_q + 32'd1;
    end else begin
      rec_cnt_d = rec_cnt_q;
    end
    if ((state_q == ST_SPEC) && bus.vp_done && !bus.en_recover && (conf_cnt_q != 32'hFFFF_FFFF)) begin
      conf_cnt_d = conf_cnt_q + 32'd1;
    end else begin
      conf_cnt_d = conf_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_cnt_q  <= 32'd0;
      conf_cnt_q <= 32'd0;
    end else begin
      rec_cnt_q  <= rec_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign bus.recover_cnt = rec_cnt_q;
  assign bus.confirm_cnt = conf_cnt_q;
`endif

endmodule
